// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, 32 steps per operation.
// Divide-by-zero and signed overflow skip the iteration and finish directly.
module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            md_stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [4:0]          cnt_q;
    logic                neg_q;
    logic [XLEN-1:0]     opb_q;
    logic [2*XLEN-1:0]   acc_q;

    logic                accept, a_signed, b_signed, sa, sb, neg_in;
    logic                div_zero, div_ovf, fast;
    logic [XLEN-1:0]     mag1, mag2, fast_res, calc_res, quo_fix, rem_fix;
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, step, prod_fix;

    assign accept   = start && !flush;
    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign sa       = a_signed && rs1_val[XLEN-1];
    assign sb       = b_signed && rs2_val[XLEN-1];
    assign mag1     = sa ? -rs1_val : rs1_val;
    assign mag2     = sb ? -rs2_val : rs2_val;
    // REM follows the dividend sign; every other signed op uses the sign product
    assign neg_in   = (op == 3'b110) ? sa : (sa ^ sb);

    assign div_zero = op[2] && (rs2_val == '0);
    assign div_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                      (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = op[1] ? rs1_val : '1;
        else if (div_ovf)
            fast_res = op[1] ? '0 : rs1_val;
    end

    // Multiply: acc = {partial, multiplier}; multiplicand held in opb_q
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; divisor held in opb_q
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign step      = op_q[2] ? div_next : mul_next;

    assign prod_fix  = neg_q ? -step : step;
    assign quo_fix   = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    assign rem_fix   = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

    always_comb begin
        calc_res = '0;
        case (op_q)
            3'b000:                 calc_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_res = quo_fix;
            default:                calc_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        md_stall = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    md_stall = 1'b1;
                    state_d  = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    md_stall = 1'b1;
                    if (cnt_q == 5'd31)
                        state_d = DONE;
                end
            end
            DONE: begin
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            md_stall = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        cnt_q <= '0;
                        neg_q <= neg_in;
                        opb_q <= op[2] ? mag2 : mag1;
                        acc_q <= {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
                        if (fast)
                            result <= fast_res;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc_q <= step;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31)
                            result <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: arithmetic results, latency, fast paths, flush and reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        md_stall;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .flush    (flush),
        .md_stall (md_stall),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    // Presents one operation at the next negedge and measures cycles to done and stall cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output int lat, output int stalls,
                          output logic [31:0] res);
        lat    = 0;
        stalls = 0;
        res    = 'x;
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; start = 1'b1;
        while (lat < 40) begin
            #1;
            if (done) begin
                res = result;
                break;
            end
            if (md_stall) stalls++;
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; flush = 1'b0; op = 3'b000;
        rs1_val = 32'd3; rs2_val = 32'd4;
        #2;
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp %h", result, 32'h0); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", md_stall); end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul;
        logic [2:0]  v_op  [6] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000, 3'b001};
        logic [31:0] v_a   [6] = '{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
        logic [31:0] v_b   [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000010, 32'h80000000};
        logic [31:0] v_exp [6] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h23456780, 32'h40000000};
        int lat, stalls;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], 1'b0, lat, stalls, res);
            n_cmp++; if (res !== v_exp[i]) begin n_err++; $display("FAIL mul_result[%0d] got %h exp %h", i, res, v_exp[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency[%0d] got %0d exp 33", i, lat); end
            n_cmp++; if (stalls !== 33) begin n_err++; $display("FAIL mul_stall_cycles[%0d] got %0d exp 33", i, stalls); end
            n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL mul_stall_in_done[%0d] got %b exp 0", i, md_stall); end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mul_done_pulse[%0d] got %b exp 0", i, done); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  v_op  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b111};
        logic [31:0] v_a   [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd7, 32'd7, 32'd100};
        logic [31:0] v_b   [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7};
        logic [31:0] v_exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1, 32'hE, 32'h1, 32'hFFFFFFFD, 32'h2};
        int lat, stalls;
        logic [31:0] res;
        for (int i = 0; i < 8; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], 1'b0, lat, stalls, res);
            n_cmp++; if (res !== v_exp[i]) begin n_err++; $display("FAIL div_result[%0d] got %h exp %h", i, res, v_exp[i]); end
            n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency[%0d] got %0d exp 33", i, lat); end
        end
    endtask

    task automatic test_div_fast;
        logic [2:0]  v_op  [6] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100, 3'b111};
        logic [31:0] v_a   [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h0, 32'h1234};
        logic [31:0] v_b   [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] v_exp [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1234};
        int lat, stalls;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], 1'b0, lat, stalls, res);
            n_cmp++; if (res !== v_exp[i]) begin n_err++; $display("FAIL fast_result[%0d] got %h exp %h", i, res, v_exp[i]); end
            n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL fast_latency[%0d] got %0d exp 1", i, lat); end
            n_cmp++; if (stalls !== 1) begin n_err++; $display("FAIL fast_stall_cycles[%0d] got %0d exp 1", i, stalls); end
        end
    endtask

    task automatic test_flush_idle;
        @(negedge clk);
        op = 3'b000; rs1_val = 32'd2; rs2_val = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall got %b exp 0", md_stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL flush_idle_not_accepted got %b exp 0", md_stall); end
    endtask

    task automatic test_flush_calc;
        logic [31:0] prev;
        bit seen = 1'b0;
        int lat, stalls;
        logic [31:0] res;
        prev = result;
        @(negedge clk);
        op = 3'b100; rs1_val = 32'hFFFFFF9C; rs2_val = 32'd7; start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1; if (done) seen = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL flush_calc_stall got %b exp 0", md_stall); end
        if (done) seen = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (result !== prev) begin n_err++; $display("FAIL flush_calc_result got %h exp %h", result, prev); end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_calc_done got %b exp 0", seen); end
        run_op(3'b100, 32'd100, 32'd7, 1'b0, lat, stalls, res);
        n_cmp++; if (res !== 32'hE) begin n_err++; $display("FAIL flush_restart_result got %h exp %h", res, 32'hE); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL flush_restart_latency got %0d exp 33", lat); end
    endtask

    task automatic test_flush_done;
        @(negedge clk);
        op = 3'b101; rs1_val = 32'd9; rs2_val = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done_pulse got %b exp 0", done); end
        n_cmp++; if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL flush_done_result got %h exp %h", result, 32'hFFFFFFFF); end
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL flush_done_idle got %b exp 0", md_stall); end
    endtask

    task automatic test_back_to_back;
        int lat, stalls;
        logic [31:0] res;
        run_op(3'b000, 32'd3, 32'd4, 1'b1, lat, stalls, res);
        n_cmp++; if (res !== 32'd12) begin n_err++; $display("FAIL b2b_first_result got %h exp %h", res, 32'd12); end
        run_op(3'b000, 32'd5, 32'd6, 1'b0, lat, stalls, res);
        n_cmp++; if (res !== 32'd30) begin n_err++; $display("FAIL b2b_second_result got %h exp %h", res, 32'd30); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency got %0d exp 33", lat); end
    endtask

    task automatic test_reset_mid;
        int lat, stalls;
        logic [31:0] res;
        @(negedge clk);
        op = 3'b011; rs1_val = 32'hFFFFFFFF; rs2_val = 32'hFFFFFFFF; start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rst_mid_result got %h exp %h", result, 32'h0); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done got %b exp 0", done); end
        n_cmp++; if (md_stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got %b exp 0", md_stall); end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b011, 32'h00010000, 32'h00010000, 1'b0, lat, stalls, res);
        n_cmp++; if (res !== 32'h1) begin n_err++; $display("FAIL rst_next_result got %h exp %h", res, 32'h1); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL rst_next_latency got %0d exp 33", lat); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_div;
        test_div_fast;
        test_flush_idle;
        test_flush_calc;
        test_flush_done;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  the EX stage holds a valid M-extension instruction.
REQ-005 SHALL have port op  input  3  the funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_val  input  32  the forwarded first operand.
REQ-007 SHALL have port rs2_val  input  32  the forwarded second operand.
REQ-008 SHALL have port flush  input  1  the EX-stage flush (mispredict or trap), which cancels the operation.
REQ-009 SHALL have port md_stall  output  1  a stall request to the hazard logic that freezes PC, IF/ID, ID/EX and EX.
REQ-010 SHALL have port done  output  1  a one-cycle pulse marking result as valid.
REQ-011 SHALL have port result  output  32  the registered result, held until the next done.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 and flush=0, the block SHALL latch op and the operands, convert signed operands to magnitudes (per op), clear the 5-bit iteration counter and go to CALC.
REQ-014 md_stall SHALL be combinational: 1 in IDLE when start=1 and flush=0, 1 in CALC, and 0 in DONE and in all other cases.
REQ-015 In CALC, each cycle SHALL perform one radix-2 step: shift-add for multiply (64-bit accumulator), restoring shift-subtract for divide; the counter SHALL increment.
REQ-016 When the counter is 31 in CALC, the next state SHALL be DONE, giving exactly 32 CALC cycles.
REQ-017 Latency SHALL be as follows: accept at cycle T; CALC at T+1..T+32; DONE at T+33; md_stall high at T..T+32.
REQ-018 In DONE, result SHALL already be registered, done SHALL equal NOT flush, and the next state SHALL be IDLE unconditionally.
REQ-019 start in DONE is the same instruction being retired and SHALL be ignored; a new operation SHALL be accepted at the earliest in the following IDLE cycle.
REQ-020 Sign fix-up: MULH SHALL negate the 64-bit product when sign(rs1) XOR sign(rs2); MULHSU SHALL negate when sign(rs1) only; MUL SHALL return the low 32 bits; the high variants SHALL return the high 32 bits.
REQ-021 DIV/REM sign fix-up: the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend; DIVU/REMU SHALL have no fix-up.
REQ-022 Divide by zero (rs2_val=0, ops 1xx) SHALL take a fast path IDLE->DONE: the quotient SHALL be 0xFFFFFFFF and the remainder SHALL be rs1_val, with md_stall high for the accept cycle only.
REQ-023 Signed overflow (DIV/REM with rs1_val=0x80000000 and rs2_val=0xFFFFFFFF) SHALL take the fast path: DIV SHALL give 0x80000000 and REM SHALL give 0.
REQ-024 A flush in IDLE SHALL block acceptance; a flush in CALC SHALL force the next state to IDLE with md_stall dropping that cycle, and done SHALL never pulse for the cancelled operation.
REQ-025 result SHALL not change on a cancelled operation; it SHALL update only on the edge entering DONE.

Reset
REQ-026 rst=1 SHALL force state to IDLE, the counter and internal operand registers to 0, result to 0x00000000, and done and md_stall to 0, regardless of clk.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release, the block SHALL be in IDLE and accept start on the first clock.

Verification
REQ-028 MUL: 7 * -3 (0x00000007, 0xFFFFFFFD) accepted at T -> md_stall high for 33 cycles; done at T+33; result=0xFFFFFFEB.
REQ-029 MULHU: 0xFFFFFFFF * 0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0x00000000.
REQ-030 DIV -7/2 -> result=0xFFFFFFFD; REM -7/2 -> result=0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> result=0x7FFFFFFC.
REQ-031 DIVU 5/0 -> done at T+1, result=0xFFFFFFFF; REM 5/0 -> result=5; DIV 0x80000000/-1 -> result=0x80000000 at T+1.
REQ-032 DIV started at T with flush=1 at T+10 -> md_stall=0 at T+10; no done ever; result is unchanged; a new start at T+11 is accepted normally.
REQ-033 rst pulsed at T+5 of a MULHU -> result=0, done=0, state=IDLE; the next operation completes with correct value and 33-cycle latency.
